// File: rtl/slug_pkg.sv
// Shared op-code and sequencer state encodings for the address register bank.
package slug_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LDNIB = 3'd1,
    OP_LDSEQ = 3'd2,
    OP_CLR   = 3'd3,
    OP_INC   = 3'd4,
    OP_DEC   = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RIPPLE = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_addsub.sv
// One DW-bit slice of the serial incrementer/decrementer: a +/- cin, carry or borrow out.
module nibble_addsub #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic          cin,
  input  logic          sub,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW:0] ext;

  // Top bit of the extended result is the carry (add) or the borrow (sub).
  always_comb begin
    if (sub) ext = {1'b0, a} - {{DW{1'b0}}, cin};
    else     ext = {1'b0, a} + {{DW{1'b0}}, cin};
  end

  assign s    = ext[DW-1:0];
  assign cout = ext[DW];

endmodule

// File: rtl/addr_reg_bank.sv
// Bank of address registers loaded a nibble at a time, with a nibble-serial INC/DEC
// sequencer that writes back only once the full result is formed.
module addr_reg_bank
  import slug_pkg::*;
#(
  parameter  int NREGS = 2,
  parameter  int AW    = 16,
  parameter  int DW    = 4,
  localparam int NNIB  = AW / DW,
  localparam int RW    = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int NW    = (NNIB > 1) ? $clog2(NNIB) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [RW-1:0] rsel,
  input  logic [NW-1:0] nsel,
  input  logic [DW-1:0] din,
  input  logic [RW-1:0] osel,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  localparam logic [RW:0]   NREGS_W = (RW+1)'(NREGS);
  localparam logic [NW:0]   NNIB_W  = (NW+1)'(NNIB);
  localparam logic [NW-1:0] LAST    = NW'(NNIB - 1);

  logic [NREGS-1:0][AW-1:0] regs;
  logic [NREGS-1:0][NW-1:0] ptr;
  logic [AW-1:0]            acc, acc_wb;
  logic [NW-1:0]            nidx;
  logic [RW-1:0]            tsel;
  logic                     carry, mode_dec, wrap_q, done_q;
  logic                     accept, last_nib, rsel_ok, nsel_ok, osel_ok, valid_op;
  logic [DW-1:0]            nib_in, nib_out;
  logic                     nib_cout;
  state_e                   state_q, state_d;
  op_e                      op_t;

  assign op_t     = op_e'(op);
  assign rsel_ok  = {1'b0, rsel} < NREGS_W;
  assign osel_ok  = {1'b0, osel} < NREGS_W;
  assign nsel_ok  = {1'b0, nsel} < NNIB_W;
  assign valid_op = (op_t == OP_LDNIB) || (op_t == OP_LDSEQ) || (op_t == OP_CLR) ||
                    (op_t == OP_INC)   || (op_t == OP_DEC);

  assign nib_in = acc[nidx*DW +: DW];

  nibble_addsub #(.DW(DW)) u_nib (
    .a    (nib_in),
    .cin  (carry),
    .sub  (mode_dec),
    .s    (nib_out),
    .cout (nib_cout)
  );

  // Accumulator with the current nibble already merged, so the last edge can write it back.
  always_comb begin
    acc_wb = acc;
    acc_wb[nidx*DW +: DW] = nib_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_nib = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept = op_valid;
        if (op_valid && rsel_ok && ((op_t == OP_INC) || (op_t == OP_DEC)))
          state_d = ST_RIPPLE;
      end
      ST_RIPPLE: begin
        last_nib = (nidx == LAST);
        if (last_nib) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs     <= '0;
      ptr      <= '0;
      acc      <= '0;
      nidx     <= '0;
      tsel     <= '0;
      carry    <= 1'b0;
      mode_dec <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (valid_op) wrap_q <= 1'b0;
        case (op_t)
          OP_LDNIB: if (rsel_ok && nsel_ok) regs[rsel][nsel*DW +: DW] <= din;
          OP_LDSEQ: if (rsel_ok) begin
            regs[rsel][ptr[rsel]*DW +: DW] <= din;
            if (ptr[rsel] == LAST) begin
              ptr[rsel] <= '0;
              done_q    <= 1'b1;
            end else begin
              ptr[rsel] <= ptr[rsel] + 1'b1;
            end
          end
          OP_CLR: if (rsel_ok) begin
            regs[rsel] <= '0;
            ptr[rsel]  <= '0;
          end
          OP_INC, OP_DEC: if (rsel_ok) begin
            acc      <= regs[rsel];
            nidx     <= '0;
            carry    <= 1'b1;
            mode_dec <= (op_t == OP_DEC);
            tsel     <= rsel;
          end
          default: ;
        endcase
      end else if (state_q == ST_RIPPLE) begin
        acc   <= acc_wb;
        carry <= nib_cout;
        nidx  <= nidx + 1'b1;
        if (last_nib) begin
          regs[tsel] <= acc_wb;
          wrap_q     <= nib_cout;
          done_q     <= 1'b1;
        end
      end
    end
  end

  assign addr = osel_ok ? regs[osel] : '0;
  assign busy = (state_q == ST_RIPPLE);
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_addr_reg_bank.sv
// Directed checks of the address register bank at default and wide (4 x 24-bit) sizes.
module tb_addr_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_rsel, a_osel, a_busy, a_done, a_wrap;
  logic [2:0]  a_op;
  logic [1:0]  a_nsel;
  logic [3:0]  a_din;
  logic [15:0] a_addr;
  logic        b_valid, b_busy, b_done, b_wrap;
  logic [2:0]  b_op, b_nsel;
  logic [1:0]  b_rsel, b_osel;
  logic [3:0]  b_din;
  logic [23:0] b_addr;
  int          cmp = 0;
  int          mis = 0;

  always #5 clk = ~clk;

  addr_reg_bank u_dut (
    .clk(clk), .rst(rst), .op_valid(a_valid), .op(a_op), .rsel(a_rsel), .nsel(a_nsel),
    .din(a_din), .osel(a_osel), .addr(a_addr), .busy(a_busy), .done(a_done), .wrap(a_wrap)
  );

  addr_reg_bank #(.NREGS(4), .AW(24), .DW(4)) u_big (
    .clk(clk), .rst(rst), .op_valid(b_valid), .op(b_op), .rsel(b_rsel), .nsel(b_nsel),
    .din(b_din), .osel(b_osel), .addr(b_addr), .busy(b_busy), .done(b_done), .wrap(b_wrap)
  );

  task automatic issue_a(input logic [2:0] op, input logic rs, input logic [1:0] ns,
                         input logic [3:0] d);
    a_valid = 1'b1; a_op = op; a_rsel = rs; a_nsel = ns; a_din = d;
    @(posedge clk); #1;
    a_valid = 1'b0; a_op = 3'd0;
  endtask

  task automatic issue_b(input logic [2:0] op, input logic [1:0] rs, input logic [2:0] ns,
                         input logic [3:0] d);
    b_valid = 1'b1; b_op = op; b_rsel = rs; b_nsel = ns; b_din = d;
    @(posedge clk); #1;
    b_valid = 1'b0; b_op = 3'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    cmp++; if (a_addr !== 16'h0) begin mis++; $display("FAIL reset_addr got %h exp 0000", a_addr); end
    cmp++; if ({a_busy, a_done, a_wrap} !== 3'b000) begin mis++; $display("FAIL reset_flags got %b exp 000", {a_busy, a_done, a_wrap}); end
    cmp++; if (b_addr !== 24'h0) begin mis++; $display("FAIL reset_big_addr got %h exp 000000", b_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ldnib;
    a_osel = 1'b0;
    issue_a(3'd1, 1'b0, 2'd0, 4'h4);
    issue_a(3'd1, 1'b0, 2'd1, 4'h3);
    issue_a(3'd1, 1'b0, 2'd2, 4'h2);
    issue_a(3'd1, 1'b0, 2'd3, 4'h1);
    cmp++; if (a_addr !== 16'h1234) begin mis++; $display("FAIL ldnib_reg0 got %h exp 1234", a_addr); end
    cmp++; if (a_done !== 1'b0) begin mis++; $display("FAIL ldnib_done got %b exp 0", a_done); end
    a_osel = 1'b1; #1;
    cmp++; if (a_addr !== 16'h0000) begin mis++; $display("FAIL ldnib_reg1 got %h exp 0000", a_addr); end
  endtask

  task automatic test_ldseq;
    logic [3:0] d;
    a_osel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 4'hA + 4'(i);
      issue_a(3'd2, 1'b1, 2'd0, d);
      cmp++; if (a_done !== (i == 3)) begin mis++; $display("FAIL ldseq_done[%0d] got %b exp %b", i, a_done, (i == 3)); end
    end
    cmp++; if (a_addr !== 16'hDCBA) begin mis++; $display("FAIL ldseq_reg1 got %h exp DCBA", a_addr); end
    @(posedge clk); #1;
    cmp++; if (a_done !== 1'b0) begin mis++; $display("FAIL ldseq_done_pulse got %b exp 0", a_done); end
  endtask

  task automatic test_inc_ripple;
    a_osel = 1'b0;
    issue_a(3'd3, 1'b0, 2'd0, 4'h0);
    issue_a(3'd1, 1'b0, 2'd0, 4'hF);
    issue_a(3'd1, 1'b0, 2'd1, 4'hF);
    cmp++; if (a_addr !== 16'h00FF) begin mis++; $display("FAIL inc_preload got %h exp 00FF", a_addr); end
    issue_a(3'd4, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cmp++; if (a_busy !== 1'b1 || a_addr !== 16'h00FF) begin mis++; $display("FAIL inc_busy[%0d] got busy=%b addr=%h exp busy=1 addr=00FF", i, a_busy, a_addr); end
      if (i == 1) begin a_valid = 1'b1; a_op = 3'd3; a_rsel = 1'b0; end
      if (i == 2) begin a_valid = 1'b0; a_op = 3'd0; end
      @(posedge clk); #1;
    end
    cmp++; if (a_addr !== 16'h0100) begin mis++; $display("FAIL inc_result got %h exp 0100", a_addr); end
    cmp++; if ({a_busy, a_done, a_wrap} !== 3'b010) begin mis++; $display("FAIL inc_flags got %b exp 010", {a_busy, a_done, a_wrap}); end
  endtask

  task automatic test_back_to_back;
    // Still in the done cycle left by test_inc_ripple.
    issue_a(3'd4, 1'b0, 2'd0, 4'h0);
    cmp++; if ({a_busy, a_done} !== 2'b10) begin mis++; $display("FAIL b2b_accept got %b exp 10", {a_busy, a_done}); end
    repeat (4) @(posedge clk);
    #1;
    cmp++; if (a_addr !== 16'h0101) begin mis++; $display("FAIL b2b_result got %h exp 0101", a_addr); end
    cmp++; if (a_done !== 1'b1) begin mis++; $display("FAIL b2b_done got %b exp 1", a_done); end
  endtask

  task automatic test_nop;
    issue_a(3'd0, 1'b0, 2'd0, 4'h7);
    issue_a(3'd7, 1'b0, 2'd0, 4'h7);
    cmp++; if (a_addr !== 16'h0101 || a_busy !== 1'b0) begin mis++; $display("FAIL nop_hold got addr=%h busy=%b exp 0101/0", a_addr, a_busy); end
  endtask

  task automatic test_wrap;
    a_osel = 1'b0;
    issue_a(3'd3, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 4; i++) issue_a(3'd2, 1'b0, 2'd0, 4'hF);
    cmp++; if (a_addr !== 16'hFFFF) begin mis++; $display("FAIL wrap_preload got %h exp FFFF", a_addr); end
    issue_a(3'd4, 1'b0, 2'd0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    cmp++; if (a_addr !== 16'h0000 || a_wrap !== 1'b1) begin mis++; $display("FAIL wrap_inc got addr=%h wrap=%b exp 0000/1", a_addr, a_wrap); end
    issue_a(3'd5, 1'b0, 2'd0, 4'h0);
    cmp++; if (a_wrap !== 1'b0) begin mis++; $display("FAIL wrap_clear_on_accept got %b exp 0", a_wrap); end
    repeat (4) @(posedge clk);
    #1;
    cmp++; if (a_addr !== 16'hFFFF || a_wrap !== 1'b1) begin mis++; $display("FAIL wrap_dec got addr=%h wrap=%b exp FFFF/1", a_addr, a_wrap); end
    issue_a(3'd3, 1'b0, 2'd0, 4'h0);
    cmp++; if (a_addr !== 16'h0000 || a_wrap !== 1'b0) begin mis++; $display("FAIL wrap_clr got addr=%h wrap=%b exp 0000/0", a_addr, a_wrap); end
  endtask

  task automatic test_reset_mid;
    a_osel = 1'b0;
    issue_a(3'd1, 1'b0, 2'd0, 4'hF);
    issue_a(3'd1, 1'b0, 2'd1, 4'hF);
    issue_a(3'd4, 1'b0, 2'd0, 4'h0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    cmp++; if (a_addr !== 16'h0 || {a_busy, a_done, a_wrap} !== 3'b000) begin mis++; $display("FAIL rst_mid got addr=%h flags=%b exp 0000/000", a_addr, {a_busy, a_done, a_wrap}); end
    a_osel = 1'b1; #1;
    cmp++; if (a_addr !== 16'h0) begin mis++; $display("FAIL rst_mid_reg1 got %h exp 0000", a_addr); end
    a_osel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cmp++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_addr !== 16'h0) begin mis++; $display("FAIL rst_mid_after[%0d] got done=%b busy=%b addr=%h exp 0/0/0000", i, a_done, a_busy, a_addr); end
    end
  endtask

  task automatic test_wide;
    logic [3:0] nibs [6];
    nibs = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h2, 4'h1};
    b_osel = 2'd3;
    for (int i = 0; i < 6; i++) begin
      issue_b(3'd2, 2'd3, 3'd0, nibs[i]);
      cmp++; if (b_done !== (i == 5)) begin mis++; $display("FAIL wide_ldseq_done[%0d] got %b exp %b", i, b_done, (i == 5)); end
    end
    cmp++; if (b_addr !== 24'h12FFFF) begin mis++; $display("FAIL wide_preload got %h exp 12FFFF", b_addr); end
    issue_b(3'd4, 2'd3, 3'd0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      cmp++; if (b_busy !== 1'b1 || b_addr !== 24'h12FFFF) begin mis++; $display("FAIL wide_busy[%0d] got busy=%b addr=%h exp 1/12FFFF", i, b_busy, b_addr); end
      @(posedge clk); #1;
    end
    cmp++; if (b_addr !== 24'h130000 || {b_busy, b_done, b_wrap} !== 3'b010) begin mis++; $display("FAIL wide_inc got addr=%h flags=%b exp 130000/010", b_addr, {b_busy, b_done, b_wrap}); end
    b_osel = 2'd0;
    issue_b(3'd1, 2'd0, 3'd6, 4'h9);
    issue_b(3'd1, 2'd0, 3'd7, 4'h9);
    cmp++; if (b_addr !== 24'h0) begin mis++; $display("FAIL wide_nsel_oob got %h exp 000000", b_addr); end
    issue_b(3'd1, 2'd0, 3'd5, 4'h9);
    cmp++; if (b_addr !== 24'h900000) begin mis++; $display("FAIL wide_nsel_top got %h exp 900000", b_addr); end
  endtask

  initial begin
    a_valid = 1'b0; a_op = 3'd0; a_rsel = 1'b0; a_nsel = 2'd0; a_din = 4'h0; a_osel = 1'b0;
    b_valid = 1'b0; b_op = 3'd0; b_rsel = 2'd0; b_nsel = 3'd0; b_din = 4'h0; b_osel = 2'd0;
    test_reset;
    test_ldnib;
    test_ldseq;
    test_inc_ripple;
    test_back_to_back;
    test_nop;
    test_wrap;
    test_reset_mid;
    test_wide;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
